// File: rtl/cel_pixel_decoder.sv
// cel_pixel_decoder: turns unpacker pixel codes into RGB555 pixels via a DMA-loaded 32-entry PLUT.
// Optional macro PIX_BGND_EN adds the pix_bgnd input (zero-valued pixels become opaque black).
module cel_pixel_decoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  bpp,
  input  logic [4:0]  pip_base,
  input  logic        plut_load,
  input  logic [31:0] plut_din,
  output logic        plut_rd_req,
  output logic        plut_busy,
  input  logic [15:0] col_in,
  input  logic        col_valid,
  output logic        next_pix,
  output logic [15:0] pix_out,
  output logic        pix_transp,
  output logic        pix_valid,
`ifdef PIX_BGND_EN
  input  logic        pix_bgnd,
`endif
  input  logic        pix_ready
);

  localparam int PLUT_ENTRIES = 32;
  localparam int IDX_W        = 5;
  localparam int CNT_W        = IDX_W - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [15:0]        plut_q [PLUT_ENTRIES];

  logic               load_ok_s;
  logic [CNT_W-1:0]   load_last_s;
  logic               wr_en_s;
  logic               accept_s;
  logic               bgnd_s;
  logic [IDX_W-1:0]   idx_s;
  logic [15:0]        res_s;
  logic               res_transp_s;

  logic               pix_valid_q, pix_valid_d;
  logic [15:0]        pix_out_q, pix_out_d;
  logic               pix_transp_q, pix_transp_d;

`ifdef PIX_BGND_EN
  assign bgnd_s = pix_bgnd;
`else
  assign bgnd_s = 1'b0;
`endif

  // PLUT word count per depth, as the index of the last word; 8/16 BPP and undefined codes load nothing
  always_comb begin
    load_ok_s   = 1'b1;
    load_last_s = 4'd0;
    case (bpp)
      3'd1:    load_last_s = 4'd0;
      3'd2:    load_last_s = 4'd1;
      3'd3:    load_last_s = 4'd7;
      3'd4:    load_last_s = 4'd15;
      default: begin
        load_ok_s   = 1'b0;
        load_last_s = 4'd0;
      end
    endcase
  end

  // load FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // load FSM next state: one DMA word captured per LOAD cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (plut_load && load_ok_s) begin
          state_d = ST_LOAD;
          cnt_d   = 4'd0;
          last_d  = load_last_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        wr_en_s = 1'b1;
        if (cnt_q == last_q) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // request and busy both come straight from the state flop
  assign plut_rd_req = (state_q == ST_LOAD);
  assign plut_busy   = (state_q == ST_LOAD);

  // PLUT storage: word k fills entries 2k (upper half) and 2k+1 (lower half)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PLUT_ENTRIES; i++) begin
        plut_q[i] <= 16'h0000;
      end
    end else if (wr_en_s) begin
      plut_q[{cnt_q, 1'b0}] <= plut_din[31:16];
      plut_q[{cnt_q, 1'b1}] <= plut_din[15:0];
    end else begin
      plut_q[0] <= plut_q[0];
    end
  end

  // pixel code conversion; 8 BPP widens each RGB332 field by bit replication
  always_comb begin
    idx_s = 5'd0;
    res_s = 16'haaaa;
    case (bpp)
      3'd1: begin
        idx_s = {4'd0, col_in[0]} | pip_base;
        res_s = plut_q[idx_s];
      end
      3'd2: begin
        idx_s = {3'd0, col_in[1:0]} | pip_base;
        res_s = plut_q[idx_s];
      end
      3'd3: begin
        idx_s = {1'b0, col_in[3:0]} | pip_base;
        res_s = plut_q[idx_s];
      end
      3'd4: begin
        idx_s = col_in[4:0];
        res_s = plut_q[idx_s];
      end
      3'd5: res_s = {1'b0, col_in[7:5], col_in[7:6], col_in[4:2], col_in[4:3],
                     col_in[1:0], col_in[1:0], col_in[1]};
      3'd6: res_s = col_in;
      default: res_s = 16'haaaa;
    endcase
  end

  assign res_transp_s = (res_s == 16'h0000) & ~bgnd_s;

  // a stalled pixel may be replaced in the same cycle it is taken downstream
  assign accept_s = reset_n & col_valid & ~plut_busy & (~pix_valid_q | pix_ready);
  assign next_pix = accept_s;

  // output register next state
  always_comb begin
    pix_valid_d  = pix_valid_q;
    pix_out_d    = pix_out_q;
    pix_transp_d = pix_transp_q;
    if (accept_s) begin
      pix_valid_d  = 1'b1;
      pix_out_d    = res_s;
      pix_transp_d = res_transp_s;
    end else if (pix_ready) begin
      pix_valid_d  = 1'b0;
    end else begin
      pix_valid_d  = pix_valid_q;
    end
  end

  // output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q  <= 1'b0;
      pix_out_q    <= 16'h0000;
      pix_transp_q <= 1'b0;
    end else begin
      pix_valid_q  <= pix_valid_d;
      pix_out_q    <= pix_out_d;
      pix_transp_q <= pix_transp_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_out    = pix_out_q;
  assign pix_transp = pix_transp_q;

endmodule

// File: tb/tb_cel_pixel_decoder.sv
// Self-checking bench for cel_pixel_decoder: cycle model of PLUT loads and the pixel handshake,
// compared every cycle, plus hand-computed literal expectations.
module tb_cel_pixel_decoder;

  logic        clock;
  logic        reset_n;
  logic [2:0]  bpp;
  logic [4:0]  pip_base;
  logic        plut_load;
  logic [31:0] plut_din;
  logic        plut_rd_req;
  logic        plut_busy;
  logic [15:0] col_in;
  logic        col_valid;
  logic        next_pix;
  logic [15:0] pix_out;
  logic        pix_transp;
  logic        pix_valid;
  logic        pix_ready;
  logic        bgnd_v;
`ifdef PIX_BGND_EN
  logic        pix_bgnd;
  assign pix_bgnd = bgnd_v;
`endif

  cel_pixel_decoder dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bpp         (bpp),
    .pip_base    (pip_base),
    .plut_load   (plut_load),
    .plut_din    (plut_din),
    .plut_rd_req (plut_rd_req),
    .plut_busy   (plut_busy),
    .col_in      (col_in),
    .col_valid   (col_valid),
    .next_pix    (next_pix),
    .pix_out     (pix_out),
    .pix_transp  (pix_transp),
    .pix_valid   (pix_valid),
`ifdef PIX_BGND_EN
    .pix_bgnd    (pix_bgnd),
`endif
    .pix_ready   (pix_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_plut [32];
  int          m_left;
  int          m_n;
  logic        m_valid;
  logic [15:0] m_out;
  logic        m_transp;

  function automatic int m_words(input logic [2:0] b);
    case (b)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 8;
      3'd4: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] m_pix(input logic [2:0] b, input logic [15:0] c, input logic [4:0] pip);
    int code, r, g, bl;
    code = int'(c);
    case (b)
      3'd1: return m_plut[(code % 2) | int'(pip)];
      3'd2: return m_plut[(code % 4) | int'(pip)];
      3'd3: return m_plut[(code % 16) | int'(pip)];
      3'd4: return m_plut[code % 32];
      3'd5: begin
        r  = (code >> 5) & 7;
        g  = (code >> 2) & 7;
        bl = code & 3;
        return 16'((r << 12) | ((r >> 1) << 10) | (g << 7) | ((g >> 1) << 5) |
                   (bl << 3) | (bl << 1) | (bl >> 1));
      end
      3'd6: return c;
      default: return 16'haaaa;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left   <= 0;
      m_n      <= 0;
      m_valid  <= 1'b0;
      m_out    <= 16'h0000;
      m_transp <= 1'b0;
      for (int i = 0; i < 32; i++) m_plut[i] <= 16'h0000;
    end else begin
      if (col_valid && m_left == 0 && (!m_valid || pix_ready)) begin
        m_valid  <= 1'b1;
        m_out    <= m_pix(bpp, col_in, pip_base);
        m_transp <= (m_pix(bpp, col_in, pip_base) == 16'h0000) && !bgnd_v;
      end else if (pix_ready) begin
        m_valid <= 1'b0;
      end
      if (m_left > 0) begin
        m_plut[2 * (m_n - m_left)]     <= plut_din[31:16];
        m_plut[2 * (m_n - m_left) + 1] <= plut_din[15:0];
        m_left <= m_left - 1;
      end else if (plut_load && m_words(bpp) > 0) begin
        m_n    <= m_words(bpp);
        m_left <= m_words(bpp);
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clock) begin
    chk("next_pix", 32'(next_pix), 32'(reset_n && col_valid && m_left == 0 && (!m_valid || pix_ready)));
    chk("plut_busy", 32'(plut_busy), 32'(m_left > 0));
    chk("plut_rd_req", 32'(plut_rd_req), 32'(m_left > 0));
    chk("pix_valid", 32'(pix_valid), 32'(m_valid));
    chk("pix_out", 32'(pix_out), 32'(m_out));
    chk("pix_transp", 32'(pix_transp), 32'(m_transp));
  end

  // ---------------- stimulus ----------------
  logic [31:0] wtab [16];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] gen6(input int k);
    if (k == 9) return 32'h1234_5678;
    return {8'h60, 8'(2 * k), 8'h61, 8'(2 * k + 1)};
  endfunction

  task automatic do_load(input int n, output int rq);
    rq = 0;
    plut_load = 1'b1;
    cyc();
    plut_load = 1'b0;
    for (int k = 0; k < n; k++) begin
      plut_din = wtab[k];
      @(negedge clock);
      if (plut_rd_req) rq++;
      cyc();
    end
    plut_din = 32'h0;
    @(negedge clock);
    if (plut_rd_req) rq++;
    cyc();
  endtask

  task automatic pix(input string nm, input logic [15:0] code, input logic [15:0] exp, input logic expt);
    col_in    = code;
    col_valid = 1'b1;
    pix_ready = 1'b1;
    @(negedge clock);
    chk({nm, "_np"}, 32'(next_pix), 32'h1);
    cyc();
    col_valid = 1'b0;
    @(negedge clock);
    chk({nm, "_valid"}, 32'(pix_valid), 32'h1);
    chk({nm, "_out"}, 32'(pix_out), 32'(exp));
    chk({nm, "_transp"}, 32'(pix_transp), 32'(expt));
    cyc();
  endtask

  initial begin
    int   rq;
    logic exp_t;
    reset_n   = 1'b1;
    bpp       = 3'd0;
    pip_base  = 5'd0;
    plut_load = 1'b0;
    plut_din  = 32'h0;
    col_in    = 16'h0;
    col_valid = 1'b0;
    pix_ready = 1'b1;
    bgnd_v    = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 32'(pix_valid), 32'h0);
    chk("rst_out", 32'(pix_out), 32'h0);
    chk("rst_busy", 32'(plut_busy), 32'h0);
    reset_n = 1'b1;
    cyc();

    // 6 BPP: full 16-word load, bit 5 of the code is ignored
    bpp = 3'd4;
    for (int k = 0; k < 16; k++) wtab[k] = gen6(k);
    do_load(16, rq);
    chk("ld6_req_cycles", 32'(rq), 32'd16);
    pix("bpp6_idx9", 16'h0029, 16'h6109, 1'b0);

    // 4 BPP: 8-word load overwrites entries 0..15 only
    bpp = 3'd3;
    wtab[0] = 32'h7FFF_001F;
    for (int k = 1; k < 8; k++) wtab[k] = {16'h0000, 16'(16'h4000 + k)};
    do_load(8, rq);
    chk("ld4_req_cycles", 32'(rq), 32'd8);
    pix("bpp4_e0", 16'h0000, 16'h7FFF, 1'b0);
    pix("bpp4_e1", 16'h0001, 16'h001F, 1'b0);
    pix("bpp4_e2", 16'h0002, 16'h0000, 1'b1);
    pip_base = 5'h10;
    pix("bpp4_pip19", 16'h0003, 16'h5678, 1'b0);
    pix("bpp4_pip19_hi", 16'hFFF3, 16'h5678, 1'b0);
    pip_base = 5'h00;

    // 8 BPP expansion; plut_load is ignored at this depth
    bpp = 3'd5;
    pix("bpp8_ff", 16'h00FF, 16'h7FFF, 1'b0);
    pix("bpp8_00", 16'h0000, 16'h0000, 1'b1);
    pix("bpp8_a9", 16'h00A9, 16'h592A, 1'b0);
    plut_load = 1'b1;
    cyc();
    plut_load = 1'b0;
    @(negedge clock);
    chk("bpp8_no_load", 32'(plut_busy), 32'h0);
    cyc();

    // 16 BPP pass-through and undefined depth codes
    bpp = 3'd6;
    pix("bpp16", 16'h8001, 16'h8001, 1'b0);
    bpp = 3'd0;
    pix("bpp0", 16'h1234, 16'haaaa, 1'b0);
    bpp = 3'd7;
    pix("bpp7", 16'h0000, 16'haaaa, 1'b0);

    // backpressure: 5 stalled cycles, then one pixel per cycle
    bpp       = 3'd6;
    col_valid = 1'b1;
    col_in    = 16'h1000;
    pix_ready = 1'b1;
    cyc();
    pix_ready = 1'b0;
    col_in    = 16'h1001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_np", 32'(next_pix), 32'h0);
      chk("stall_out", 32'(pix_out), 32'h1000);
      cyc();
    end
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      col_in = 16'(16'h1001 + i);
      @(negedge clock);
      chk("stream_np", 32'(next_pix), 32'h1);
      chk("stream_out", 32'(pix_out), 32'(16'h1000 + i));
      cyc();
    end
    col_valid = 1'b0;
    @(negedge clock);
    chk("stream_last", 32'(pix_out), 32'h1004);
    cyc();

    // col_valid held during a 2 BPP load: blocked until busy falls, then new PLUT used
    bpp     = 3'd2;
    wtab[0] = 32'hABCD_1357;
    wtab[1] = 32'h2468_0000;
    plut_load = 1'b1;
    cyc();
    plut_load = 1'b0;
    col_valid = 1'b1;
    col_in    = 16'h0001;
    for (int k = 0; k < 2; k++) begin
      plut_din = wtab[k];
      @(negedge clock);
      chk("ld_np_blocked", 32'(next_pix), 32'h0);
      chk("ld_busy", 32'(plut_busy), 32'h1);
      cyc();
    end
    plut_din = 32'h0;
    @(negedge clock);
    chk("ld_np_after", 32'(next_pix), 32'h1);
    cyc();
    col_valid = 1'b0;
    @(negedge clock);
    chk("ld_first_pix", 32'(pix_out), 32'h1357);
    cyc();
    pix("bpp2_e2", 16'h0002, 16'h2468, 1'b0);

    // reset for one cycle in the middle of a 6 BPP load
    bpp = 3'd4;
    for (int k = 0; k < 16; k++) wtab[k] = gen6(k);
    plut_load = 1'b1;
    cyc();
    plut_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      plut_din = wtab[k];
      cyc();
    end
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy", 32'(plut_busy), 32'h0);
    chk("mid_rst_req", 32'(plut_rd_req), 32'h0);
    chk("mid_rst_valid", 32'(pix_valid), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    plut_din = 32'h0;
    cyc();
    exp_t = 1'b1;
`ifdef PIX_BGND_EN
    bgnd_v = 1'b1;
    exp_t  = 1'b0;
`endif
    pix("post_rst_e20", 16'h0014, 16'h0000, exp_t);
    bpp = 3'd3;
    pix("post_rst_e5", 16'h0005, 16'h0000, exp_t);
    bgnd_v = 1'b0;
    pix("post_rst_e6", 16'h0006, 16'h0000, 1'b1);

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
